// File: rtl/mbist_march_ctrl_if.sv
// Test-side bus of the March C- controller: start/status towards the test top,
// command/data towards the single-port memory under test.
interface mbist_march_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
);
    logic                  start;
    logic                  mem_write_read;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  busy;
    logic                  done;
    logic                  fail;
    logic [CNT_WIDTH-1:0]  fail_count;
    logic [ADDR_WIDTH-1:0] fail_addr;
    logic [2:0]            fail_elem;
    logic [DATA_WIDTH-1:0] fail_expected;
    logic [DATA_WIDTH-1:0] fail_actual;

    modport master (
        input  start, mem_rdata,
        output mem_write_read, mem_address, mem_wdata,
        output busy, done, fail, fail_count,
        output fail_addr, fail_elem, fail_expected, fail_actual
    );

    modport slave (
        output start, mem_rdata,
        input  mem_write_read, mem_address, mem_wdata,
        input  busy, done, fail, fail_count,
        input  fail_addr, fail_elem, fail_expected, fail_actual
    );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller: sweeps six elements over 0..CAPACITY, checks reads two cycles later.
// Run takes 6 + 10*(CAPACITY+1) + 2 busy cycles; start is ignored while busy.
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15,
    parameter int CNT_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               rst,
    mbist_march_ctrl_if.master mbist
);
    typedef enum logic [2:0] {IDLE, SETUP, RD, WR, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                  vld;
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            elem;
        logic [DATA_WIDTH-1:0] exp;
    } cmp_t;

    localparam logic [ADDR_WIDTH-1:0] CAP_A     = ADDR_WIDTH'(CAPACITY);
    localparam logic [2:0]            LAST_ELEM = 3'd5;
    localparam logic [DATA_WIDTH-1:0] ONES      = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ZEROS     = {DATA_WIDTH{1'b0}};

    function automatic logic is_down(input logic [2:0] e);
        return e >= 3'd3;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] first_addr(input logic [2:0] e);
        return is_down(e) ? CAP_A : {ADDR_WIDTH{1'b0}};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] last_addr(input logic [2:0] e);
        return is_down(e) ? {ADDR_WIDTH{1'b0}} : CAP_A;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] wr_pat(input logic [2:0] e);
        return (e == 3'd1 || e == 3'd3) ? ONES : ZEROS;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rd_exp(input logic [2:0] e);
        return (e == 3'd2 || e == 3'd4) ? ONES : ZEROS;
    endfunction

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  drain_q, drain_d;
    cmp_t                  s1_q, s1_d, s2_q;
    logic                  fail_q;
    logic [CNT_WIDTH-1:0]  fail_count_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [2:0]            fail_elem_q;
    logic [DATA_WIDTH-1:0] fail_exp_q, fail_act_q;

    logic rd_push, run_start, adv, mismatch;

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        drain_d   = drain_q;
        rd_push   = 1'b0;
        run_start = 1'b0;
        adv       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (mbist.start) begin
                    state_d   = SETUP;
                    elem_d    = 3'd0;
                    addr_d    = first_addr(3'd0);
                    wdata_d   = wr_pat(3'd0);
                    run_start = 1'b1;
                end
            end
            SETUP: state_d = (elem_q == 3'd0) ? WR : RD;
            RD: begin
                rd_push = 1'b1;
                if (elem_q != LAST_ELEM) begin
                    state_d = WR;
                end else begin
                    adv = 1'b1;
                end
            end
            WR: adv = 1'b1;
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Terminal address is found by equality so CAPACITY need not be 2**ADDR_WIDTH-1.
        if (adv) begin
            if (addr_q == last_addr(elem_q)) begin
                if (elem_q == LAST_ELEM) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    elem_d  = elem_q + 3'd1;
                    state_d = SETUP;
                    addr_d  = first_addr(elem_q + 3'd1);
                    wdata_d = wr_pat(elem_q + 3'd1);
                end
            end else begin
                state_d = (elem_q == 3'd0) ? WR : RD;
                addr_d  = is_down(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
            end
        end

        s1_d.vld  = rd_push;
        s1_d.addr = addr_q;
        s1_d.elem = elem_q;
        s1_d.exp  = rd_exp(elem_q);
    end

    assign mismatch = s2_q.vld && (mbist.mem_rdata != s2_q.exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            elem_q       <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            drain_q      <= 1'b0;
            s1_q         <= '0;
            s2_q         <= '0;
            fail_q       <= 1'b0;
            fail_count_q <= '0;
            fail_addr_q  <= '0;
            fail_elem_q  <= 3'd0;
            fail_exp_q   <= '0;
            fail_act_q   <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            drain_q <= drain_d;
            s1_q    <= s1_d;
            s2_q    <= s1_q;
            if (run_start) begin
                fail_q       <= 1'b0;
                fail_count_q <= '0;
                fail_addr_q  <= '0;
                fail_elem_q  <= 3'd0;
                fail_exp_q   <= '0;
                fail_act_q   <= '0;
            end else if (mismatch) begin
                fail_q <= 1'b1;
                if (fail_count_q != {CNT_WIDTH{1'b1}}) begin
                    fail_count_q <= fail_count_q + 1'b1;
                end
                if (!fail_q) begin
                    fail_addr_q <= s2_q.addr;
                    fail_elem_q <= s2_q.elem;
                    fail_exp_q  <= s2_q.exp;
                    fail_act_q  <= mbist.mem_rdata;
                end
            end
        end
    end

    assign mbist.mem_write_read = (state_q == WR);
    assign mbist.mem_address    = addr_q;
    assign mbist.mem_wdata      = wdata_q;
    assign mbist.busy           = (state_q == SETUP) || (state_q == RD) ||
                                  (state_q == WR)    || (state_q == DRAIN);
    assign mbist.done           = (state_q == DONE);
    assign mbist.fail           = fail_q;
    assign mbist.fail_count     = fail_count_q;
    assign mbist.fail_addr      = fail_addr_q;
    assign mbist.fail_elem      = fail_elem_q;
    assign mbist.fail_expected  = fail_exp_q;
    assign mbist.fail_actual    = fail_act_q;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for the March C- controller with a 2-cycle-read memory model
// that can inject a stuck-at-0 or a rising-write transition fault.
module tb_mbist_march_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CW = 8;
    localparam int RUN_CYC = 168;
    localparam int TMAX = 200;

    logic clk;
    logic rst;
    int   fault_mode;
    int   n_checks;
    int   n_fail;

    mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    mbist_march_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(15), .CNT_WIDTH(CW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .mbist (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: write takes data presented the cycle before the write command.
    logic [DW-1:0] mem [0:15];
    logic [DW-1:0] wdata_prev;
    logic [DW-1:0] rd_p1;
    always @(posedge clk) begin : mem_model
        logic [DW-1:0] nv;
        logic [DW-1:0] old;
        wdata_prev <= bus.mem_wdata;
        if (bus.mem_write_read) begin
            nv  = wdata_prev;
            old = mem[bus.mem_address];
            if (fault_mode == 2 && bus.mem_address == 4'd5 && !old[1] && nv[1]) nv[2] = ~nv[2];
            if (fault_mode == 1 && bus.mem_address == 4'd0) nv[0] = 1'b0;
            mem[bus.mem_address] <= nv;
        end
        rd_p1         <= mem[bus.mem_address];
        bus.mem_rdata <= rd_p1;
    end

    logic [AW-1:0] tr_addr [0:TMAX-1];
    logic          tr_wr   [0:TMAX-1];
    logic [DW-1:0] tr_wd   [0:TMAX-1];
    logic [AW-1:0] ex_addr [0:TMAX-1];
    logic          ex_wr   [0:TMAX-1];
    logic [DW-1:0] ex_wd   [0:TMAX-1];
    logic          ex_achk [0:TMAX-1];
    logic          ex_dchk [0:TMAX-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic build_expected();
        int idx;
        logic [AW-1:0] a;
        logic [DW-1:0] pat;
        idx = 0;
        for (int e = 0; e < 6; e++) begin
            pat = (e == 1 || e == 3) ? 8'hFF : 8'h00;
            a   = (e < 3) ? 4'd0 : 4'd15;
            ex_addr[idx] = a; ex_wr[idx] = 1'b0; ex_wd[idx] = pat;
            ex_achk[idx] = 1'b1; ex_dchk[idx] = (e != 5);
            idx++;
            for (int k = 0; k < 16; k++) begin
                a = (e < 3) ? 4'(k) : 4'(15 - k);
                if (e != 0) begin
                    ex_addr[idx] = a; ex_wr[idx] = 1'b0; ex_wd[idx] = pat;
                    ex_achk[idx] = 1'b1; ex_dchk[idx] = (e != 5);
                    idx++;
                end
                if (e != 5) begin
                    ex_addr[idx] = a; ex_wr[idx] = 1'b1; ex_wd[idx] = pat;
                    ex_achk[idx] = 1'b1; ex_dchk[idx] = 1'b1;
                    idx++;
                end
            end
        end
        for (int i = idx; i < TMAX; i++) begin
            ex_addr[i] = '0; ex_wr[i] = 1'b0; ex_wd[i] = '0;
            ex_achk[i] = 1'b0; ex_dchk[i] = 1'b0;
        end
    endtask

    // Pulses start, then counts busy cycles (bounded), optionally re-pulsing start or asserting rst.
    task automatic run(input int restart_at, input int rst_at, output int cycles);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("clr_done", {31'd0, bus.done}, 32'd0);
        check("clr_fail", {31'd0, bus.fail}, 32'd0);
        check("clr_count", 32'(bus.fail_count), 32'd0);
        cycles = 0;
        while (bus.busy && cycles < 400) begin
            if (cycles < TMAX) begin
                tr_addr[cycles] = bus.mem_address;
                tr_wr[cycles]   = bus.mem_write_read;
                tr_wd[cycles]   = bus.mem_wdata;
            end
            bus.start = (cycles == restart_at);
            if (cycles == rst_at) rst = 1'b1;
            cycles++;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic check_trace();
        int ea, ew, ed, es, nw, nr;
        ea = 0; ew = 0; ed = 0; es = 0; nw = 0; nr = 0;
        for (int i = 0; i < RUN_CYC; i++) begin
            if (tr_wr[i] !== ex_wr[i]) ew++;
            if (ex_achk[i] && tr_addr[i] !== ex_addr[i]) ea++;
            if (ex_dchk[i] && tr_wd[i] !== ex_wd[i]) ed++;
            if (i > 0 && tr_wr[i] && tr_wd[i] !== tr_wd[i-1]) es++;
            if (tr_wr[i]) nw++;
            if (ex_achk[i] && !ex_wr[i] && !tr_wr[i]) nr++;
        end
        check("trace_addr_errs", 32'(ea), 32'd0);
        check("trace_wr_errs", 32'(ew), 32'd0);
        check("trace_wdata_errs", 32'(ed), 32'd0);
        check("trace_wdata_stable_errs", 32'(es), 32'd0);
        check("trace_write_count", 32'(nw), 32'd80);
        check("trace_nonwrite_op_cycles", 32'(nr), 32'd86);
    endtask

    task automatic check_status(input string pfx, input logic f, input logic [CW-1:0] cnt,
                                input logic [AW-1:0] fa, input logic [2:0] fe,
                                input logic [DW-1:0] fx, input logic [DW-1:0] fc);
        check({pfx, "_done"}, {31'd0, bus.done}, 32'd1);
        check({pfx, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({pfx, "_fail"}, {31'd0, bus.fail}, {31'd0, f});
        check({pfx, "_count"}, 32'(bus.fail_count), 32'(cnt));
        check({pfx, "_addr"}, 32'(bus.fail_addr), 32'(fa));
        check({pfx, "_elem"}, 32'(bus.fail_elem), 32'(fe));
        check({pfx, "_expected"}, 32'(bus.fail_expected), 32'(fx));
        check({pfx, "_actual"}, 32'(bus.fail_actual), 32'(fc));
    endtask

    initial begin
        int cyc;
        n_checks   = 0;
        n_fail     = 0;
        fault_mode = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        build_expected();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_fail", {31'd0, bus.fail}, 32'd0);
        check("rst_count", 32'(bus.fail_count), 32'd0);
        check("rst_wr", {31'd0, bus.mem_write_read}, 32'd0);
        check("rst_addr", 32'(bus.mem_address), 32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);

        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        check("start_with_rst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("start_with_rst_idle", {31'd0, bus.busy}, 32'd0);

        run(-1, -1, cyc);
        check("clean_busy_cycles", 32'(cyc), 32'(RUN_CYC));
        check_status("clean", 1'b0, 8'd0, 4'd0, 3'd0, 8'h00, 8'h00);
        check_trace();

        run(20, -1, cyc);
        check("restart_busy_cycles", 32'(cyc), 32'(RUN_CYC));
        check_status("restart", 1'b0, 8'd0, 4'd0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        check("done_held", {31'd0, bus.done}, 32'd1);

        fault_mode = 1;
        run(-1, -1, cyc);
        check("sa0_busy_cycles", 32'(cyc), 32'(RUN_CYC));
        check_status("sa0", 1'b1, 8'd2, 4'd0, 3'd2, 8'hFF, 8'hFE);

        fault_mode = 2;
        run(-1, -1, cyc);
        check("tf_busy_cycles", 32'(cyc), 32'(RUN_CYC));
        check_status("tf", 1'b1, 8'd2, 4'd5, 3'd2, 8'hFF, 8'hFB);

        fault_mode = 0;
        run(-1, 50, cyc);
        check("abort_cycles", 32'(cyc), 32'd51);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_wr", {31'd0, bus.mem_write_read}, 32'd0);
        check("abort_fail", {31'd0, bus.fail}, 32'd0);
        check("abort_count", 32'(bus.fail_count), 32'd0);
        check("abort_addr", 32'(bus.mem_address), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run(-1, -1, cyc);
        check("rerun_busy_cycles", 32'(cyc), 32'(RUN_CYC));
        check_status("rerun", 1'b0, 8'd0, 4'd0, 3'd0, 8'h00, 8'h00);
        check_trace();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- March C- BIST controller: the initiator that drives the single-port test memory (`write_read`, `address`, `wdata`) and checks its `rdata`.
- On a `start` pulse it runs the six March C- elements over addresses 0..CAPACITY.
- It compares every read against the expected background and reports pass/fail plus first-failure diagnostics.
- It sits between the test top level and the memory under test, with or without injected faults.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 4, memory address width.
- CAPACITY, 15, highest valid address; test covers 0..CAPACITY inclusive.
- CNT_WIDTH, 8, width of the saturating fail counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse that begins a run; ignored while busy.
- mem_write_read  output  1  1 = write, 0 = read; to memory `write_read`.
- mem_address  output  ADDR_WIDTH  to memory `address`.
- mem_wdata  output  DATA_WIDTH  to memory `wdata`.
- mem_rdata  input  DATA_WIDTH  from memory `rdata`.
- busy  output  1  run in progress.
- done  output  1  run finished; held until next start or rst.
- fail  output  1  at least one miscompare in current/last run.
- fail_count  output  CNT_WIDTH  miscompare count, saturates at all-ones.
- fail_addr  output  ADDR_WIDTH  address of first miscompare.
- fail_elem  output  3  element index (0..5) of first miscompare.
- fail_expected  output  DATA_WIDTH  expected word at first miscompare.
- fail_actual  output  DATA_WIDTH  read word at first miscompare.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, compare pipeline invalidated. Reset mid-run aborts immediately; mem_write_read is 0 in the next cycle.
- Memory timing contract:
  - Write data is sampled by the memory one cycle before the write command. mem_wdata must therefore be stable one cycle before and during every write cycle.
  - Read data appears on mem_rdata 2 cycles after the read command.
- Elements (Z = all-zeros, O = all-ones):
  - e0 up (w Z)
  - e1 up (r Z, w O)
  - e2 up (r O, w Z)
  - e3 down (r Z, w O)
  - e4 down (r O, w Z)
  - e5 down (r Z)
  - "up" runs address 0..CAPACITY; "down" runs CAPACITY..0.
- FSM states: IDLE, SETUP, RD, WR, DRAIN, DONE.
  - IDLE/DONE + start -> SETUP with elem=0. All status outputs clear; busy=1 and done=0 from the next cycle.
  - SETUP, 1 cycle:
    - mem_write_read=0.
    - mem_address = element start address.
    - mem_wdata = element write pattern (held for the whole element).
    - Then -> RD, or -> WR for e0.
  - RD, 1 cycle: read command. Pushes {valid, address, elem, expected} into a 2-stage compare pipeline. Then -> WR if the element has a write, else advance.
  - WR, 1 cycle: write command, then advance.
  - Advance: step the address up or down. At the last address of an element, go to SETUP of elem+1, or to DRAIN after e5.
  - DRAIN: 2 cycles, lets the last reads complete. Then DONE: busy=0, done=1.
- Compare: when pipeline stage 2 is valid, compare mem_rdata to expected. On mismatch:
  - fail=1.
  - fail_count increments (saturating).
  - If this is the first mismatch of the run, latch fail_addr, fail_elem, fail_expected, fail_actual. Later mismatches do not overwrite them.
- Busy duration: 6 SETUP + 10*(CAPACITY+1) op cycles + 2 DRAIN = 168 cycles at defaults.
- Address counter width is ADDR_WIDTH. Up/down terminal detection uses equality with CAPACITY or 0, never overflow.
- A start pulse coincident with rst is ignored. start while busy has no effect.

Test Plan:
- Fault-free memory, pulse start -> busy high exactly 168 cycles; then done=1, fail=0, fail_count=0, fail_* all 0.
- Stuck-at-0 on bit 0 of address 0 -> first miscompare in e2: fail_addr=0, fail_elem=2, fail_expected=8'hFF, fail_actual=8'hFE. fail_count=2 (e2 and e4 reads).
- Transition fault: a rising write of bit 1 at address 5 inverts bit 2 -> fail=1, fail_elem=2, fail_addr=5, fail_expected=8'hFF, fail_actual=8'hFB.
- Assert rst at cycle 50 of a run -> next cycle: busy=0, done=0, mem_write_read=0, all status 0. A new start then completes a clean 168-cycle run.
- start pulsed again at cycle 20 of a run -> ignored; done still at cycle 168. A second start after done clears done/fail and reruns.
- Trace check: mem_address sequence 0..15 in e0–e2 and 15..0 in e3–e5. Every write cycle has mem_wdata stable from the preceding cycle.
